// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_decoder
//  Purpose  : PS/2 keyboard receiver and scan-code decoder. Deserialises
//             device-driven PS/2 frames, tracks make / break (F0) / extended
//             (E0) sequences and presents the ASCII code of the held key.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1  system clock (50 MHz)
//    reset       in   1  asynchronous, active-high reset
//    ps2_clk     in   1  raw PS/2 clock pin (asynchronous, input only)
//    ps2_data    in   1  raw PS/2 data pin (asynchronous, input only)
//    ascii       out  8  ASCII code of the held key, 8'h00 when none
//    scan_code   out  8  last valid received byte
//    data_ready  out  1  one-cycle pulse per valid received byte
//    frame_err   out  1  one-cycle pulse per rejected frame
// ============================================================================
module ps2_key_decoder #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] ascii,
   output logic [7:0] scan_code,
   output logic       data_ready,
   output logic       frame_err
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] C_IDLE_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]      C_STOP_IDX  = 4'd10;

   // ------------------------------------------------------------------
   // Synchronisers. Reset to 1 (idle bus level) so leaving reset never
   // fabricates a falling edge.
   // ------------------------------------------------------------------
   logic r_clk_meta, r_clk_sync, r_clk_prev;
   logic r_data_meta, r_data_sync;

   // ------------------------------------------------------------------
   // Receiver state
   // ------------------------------------------------------------------
   logic [9:0]      r_shift;      // start, data[7:0], parity (oldest in bit 0)
   logic [3:0]      r_bit_cnt;
   logic [TO_W-1:0] r_idle_cnt;
   logic            r_pending;    // frame finished, result goes out next cycle
   logic            r_pend_ok;
   logic [7:0]      r_pend_byte;

   logic       w_fall;
   logic       w_expired;
   logic [3:0] w_base_cnt;

   assign w_fall     = r_clk_prev & ~r_clk_sync;
   assign w_expired  = (r_bit_cnt != 4'd0) && (r_idle_cnt == C_IDLE_LAST);
   // An edge arriving in the cycle the timeout expires starts a new frame.
   assign w_base_cnt = w_expired ? 4'd0 : r_bit_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clk_meta  <= 1'b1;
         r_clk_sync  <= 1'b1;
         r_clk_prev  <= 1'b1;
         r_data_meta <= 1'b1;
         r_data_sync <= 1'b1;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_idle_cnt  <= '0;
         r_pending   <= 1'b0;
         r_pend_ok   <= 1'b0;
         r_pend_byte <= '0;
      end else begin
         r_clk_meta  <= ps2_clk;
         r_clk_sync  <= r_clk_meta;
         r_clk_prev  <= r_clk_sync;
         r_data_meta <= ps2_data;
         r_data_sync <= r_data_meta;
         r_pending   <= 1'b0;

         if (w_fall) begin
            r_idle_cnt <= '0;
            if (w_base_cnt == C_STOP_IDX) begin
               // Stop bit: start must be 0, data+parity odd, stop must be 1.
               r_bit_cnt   <= '0;
               r_pending   <= 1'b1;
               r_pend_ok   <= ~r_shift[0] & (^r_shift[9:1]) & r_data_sync;
               r_pend_byte <= r_shift[8:1];
            end else begin
               r_shift   <= {r_data_sync, r_shift[9:1]};
               r_bit_cnt <= w_base_cnt + 4'd1;
            end
         end else if (w_expired) begin
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
         end else if (r_bit_cnt != 4'd0) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
         end else begin
            r_idle_cnt <= '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Scan-code to uppercase ASCII
   // ------------------------------------------------------------------
   function automatic logic [7:0] map_code(input logic [7:0] code);
      logic [7:0] res;
      res = 8'h00;
      case (code)
         8'h1C: res = 8'h41;  8'h32: res = 8'h42;  8'h21: res = 8'h43;
         8'h23: res = 8'h44;  8'h24: res = 8'h45;  8'h2B: res = 8'h46;
         8'h34: res = 8'h47;  8'h33: res = 8'h48;  8'h43: res = 8'h49;
         8'h3B: res = 8'h4A;  8'h42: res = 8'h4B;  8'h4B: res = 8'h4C;
         8'h3A: res = 8'h4D;  8'h31: res = 8'h4E;  8'h44: res = 8'h4F;
         8'h4D: res = 8'h50;  8'h15: res = 8'h51;  8'h2D: res = 8'h52;
         8'h1B: res = 8'h53;  8'h2C: res = 8'h54;  8'h3C: res = 8'h55;
         8'h2A: res = 8'h56;  8'h1D: res = 8'h57;  8'h22: res = 8'h58;
         8'h35: res = 8'h59;  8'h1A: res = 8'h5A;
         8'h45: res = 8'h30;  8'h16: res = 8'h31;  8'h1E: res = 8'h32;
         8'h26: res = 8'h33;  8'h25: res = 8'h34;  8'h2E: res = 8'h35;
         8'h36: res = 8'h36;  8'h3D: res = 8'h37;  8'h3E: res = 8'h38;
         8'h46: res = 8'h39;
         8'h5A: res = 8'h0D;  8'h29: res = 8'h20;
         default: res = 8'h00;
      endcase
      return res;
   endfunction

   // ------------------------------------------------------------------
   // Make / break / extended sequence decoder with registered outputs
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_BREAK     = 2'd1,
      ST_EXT       = 2'd2,
      ST_EXT_BREAK = 2'd3
   } dec_state_t;

   dec_state_t r_state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         ascii      <= 8'h00;
         scan_code  <= 8'h00;
         data_ready <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_ready <= 1'b0;
         frame_err  <= 1'b0;
         if (r_pending) begin
            if (!r_pend_ok) begin
               frame_err <= 1'b1;
            end else begin
               data_ready <= 1'b1;
               scan_code  <= r_pend_byte;
               case (r_state)
                  ST_IDLE: begin
                     if (r_pend_byte == 8'hF0)      r_state <= ST_BREAK;
                     else if (r_pend_byte == 8'hE0) r_state <= ST_EXT;
                     else                           ascii   <= map_code(r_pend_byte);
                  end
                  ST_BREAK: begin
                     // Only releasing the key currently shown clears it.
                     if (map_code(r_pend_byte) == ascii) ascii <= 8'h00;
                     r_state <= ST_IDLE;
                  end
                  ST_EXT: begin
                     if (r_pend_byte == 8'hF0) r_state <= ST_EXT_BREAK;
                     else                      r_state <= ST_IDLE;
                  end
                  ST_EXT_BREAK: r_state <= ST_IDLE;
                  default:      r_state <= ST_IDLE;
               endcase
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_decoder
//  Purpose  : Directed self-checking bench for ps2_key_decoder. PS/2 frames
//             are bit-banged on ps2_clk/ps2_data at a slow rate relative to
//             clk; expected values are hand-derived from the scan-code table.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_key_decoder;

   localparam int TO = 200;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] ascii;
   logic [7:0] scan_code;
   logic       data_ready;
   logic       frame_err;

   int total  = 0;
   int passed = 0;
   int dr_count = 0;
   int fe_count = 0;

   ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .ascii      (ascii),
      .scan_code  (scan_code),
      .data_ready (data_ready),
      .frame_err  (frame_err)
   );

   always #10 clk = ~clk;

   always @(posedge clk) begin
      if (data_ready === 1'b1) dr_count = dr_count + 1;
      if (frame_err  === 1'b1) fe_count = fe_count + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send_bit(input logic v);
      @(negedge clk);
      ps2_data = v;
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // Full frame; bad_par flips the parity bit, lat checks stop-bit latency.
   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic lat);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ bad_par);
      @(negedge clk);
      ps2_data = 1'b1;
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      if (lat) begin
         repeat (3) @(posedge clk);
         #1 check("latency_edge3_low", data_ready, 0);
         @(posedge clk);
         #1 check("latency_edge4_high", data_ready, 1);
         @(posedge clk);
         #1 check("latency_edge5_low", data_ready, 0);
      end
      repeat (10) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   // Start bit followed by n-1 further bits, then the bus goes quiet.
   task automatic send_partial(input int n);
      send_bit(1'b0);
      for (int i = 1; i < n; i++) send_bit(1'b1);
   endtask

   int dr0, fe0;

   initial begin
      // Reset state
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ascii", ascii, 8'h00);
      check("rst_scan", scan_code, 8'h00);
      check("rst_dr", data_ready, 0);
      check("rst_fe", frame_err, 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // First frame 0x1C with latency check
      dr0 = dr_count;
      send_frame(8'h1C, 1'b0, 1'b1);
      check("a_scan", scan_code, 8'h1C);
      check("a_ascii", ascii, 8'h41);

      // Typematic repeats then release
      send_frame(8'h1C, 1'b0, 1'b0);
      check("rep1_ascii", ascii, 8'h41);
      send_frame(8'h1C, 1'b0, 1'b0);
      check("rep2_ascii", ascii, 8'h41);
      send_frame(8'hF0, 1'b0, 1'b0);
      check("f0_ascii", ascii, 8'h41);
      check("f0_scan", scan_code, 8'hF0);
      send_frame(8'h1C, 1'b0, 1'b0);
      check("release_a", ascii, 8'h00);
      check("dr_pulses5", dr_count - dr0, 5);

      // Enter, then release of a different key
      send_frame(8'h5A, 1'b0, 1'b0);
      check("enter_ascii", ascii, 8'h0D);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      check("enter_kept", ascii, 8'h0D);

      // Bad parity
      dr0 = dr_count;
      fe0 = fe_count;
      send_frame(8'h16, 1'b1, 1'b0);
      check("par_fe", fe_count - fe0, 1);
      check("par_dr", dr_count - dr0, 0);
      check("par_ascii", ascii, 8'h0D);
      check("par_scan", scan_code, 8'h1C);
      send_frame(8'h16, 1'b0, 1'b0);
      check("one_ascii", ascii, 8'h31);

      // Extended sequences are ignored
      send_frame(8'h24, 1'b0, 1'b0);
      check("e_ascii", ascii, 8'h45);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h75, 1'b0, 1'b0);
      check("ext_make", ascii, 8'h45);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h75, 1'b0, 1'b0);
      check("ext_break", ascii, 8'h45);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h24, 1'b0, 1'b0);
      check("release_e", ascii, 8'h00);

      // Timeout discards a partial frame
      fe0 = fe_count;
      send_partial(5);
      repeat (TO + 10) @(negedge clk);
      send_frame(8'h2B, 1'b0, 1'b0);
      check("to_ascii", ascii, 8'h46);
      check("to_scan", scan_code, 8'h2B);
      check("to_fe", fe_count - fe0, 0);

      // Reset mid-frame
      send_partial(5);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_ascii", ascii, 8'h00);
      check("midrst_scan", scan_code, 8'h00);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      fe0 = fe_count;
      send_frame(8'h2B, 1'b0, 1'b0);
      check("post_rst_ascii", ascii, 8'h46);
      check("post_rst_scan", scan_code, 8'h2B);
      check("post_rst_fe", fe_count - fe0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
